// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory port of the loader, bundled as one bus.
interface imem_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;

  modport slave (
    input  s_valid, s_data, rdata_ext,
    output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
  );

  modport master (
    output s_valid, s_data, rdata_ext,
    input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a little-endian byte stream into instruction memory, reads it back to
// verify an XOR checksum, then enables the processor.
module imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MAX_WORDS = 128
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [7:0]   num_words,
  imem_loader_if.slave bus,
  output logic         cpu_enable,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VRD, VCMP, CHECK, RUN, ERROR} state_t;

  state_t      r_state;
  logic [7:0]  r_numWords;
  logic [7:0]  r_idx;
  logic [1:0]  r_byteCnt;
  logic [31:0] r_word;
  logic [31:0] r_loadSum;
  logic [31:0] r_rdSum;

  logic        w_numOk;
  logic        w_lastWord;
  logic        w_accept;
  logic        w_wen;
  logic        w_ren;
  logic [63:0] w_addr;

  assign w_numOk    = (num_words != 8'd0) && (32'(num_words) <= MAX_WORDS);
  assign w_lastWord = (r_idx == r_numWords - 8'd1);
  assign w_addr     = BASE_ADDR + {54'd0, r_idx, 2'b00};

  // Bus strobes are gated by abort so they drop in the very cycle abort rises.
  assign w_wen       = (r_state == WRITE) && !abort;
  assign w_ren       = (r_state == VRD) && !abort;
  assign bus.s_ready = (r_state == LOAD) && !abort;
  assign w_accept    = bus.s_valid && bus.s_ready;

  assign bus.wen_ext   = w_wen;
  assign bus.ren_ext   = w_ren;
  assign bus.addr_ext  = (w_wen || w_ren) ? w_addr : 64'd0;
  assign bus.wdata_ext = w_wen ? r_word : 32'd0;

  assign cpu_enable = (r_state == RUN) && !abort;
  assign done       = (r_state == RUN);
  assign error      = (r_state == ERROR);
  assign busy       = (r_state == LOAD) || (r_state == WRITE) || (r_state == VRD) ||
                      (r_state == VCMP) || (r_state == CHECK);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= IDLE;
      r_numWords <= 8'd0;
      r_idx      <= 8'd0;
      r_byteCnt  <= 2'd0;
      r_word     <= 32'd0;
      r_loadSum  <= 32'd0;
      r_rdSum    <= 32'd0;
    end else if (abort) begin
      r_state   <= IDLE;
      r_byteCnt <= 2'd0;
      r_word    <= 32'd0;
    end else begin
      unique case (r_state)
        IDLE, ERROR: begin
          if (start) begin
            if (w_numOk) begin
              r_numWords <= num_words;
              r_idx      <= 8'd0;
              r_byteCnt  <= 2'd0;
              r_word     <= 32'd0;
              r_loadSum  <= 32'd0;
              r_rdSum    <= 32'd0;
              r_state    <= LOAD;
            end else begin
              r_state <= ERROR;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_word[{r_byteCnt, 3'b000} +: 8] <= bus.s_data;
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) r_state <= WRITE;
          end
        end
        WRITE: begin
          r_loadSum <= r_loadSum ^ r_word;
          if (w_lastWord) begin
            r_idx   <= 8'd0;
            r_state <= VRD;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= LOAD;
          end
        end
        VRD: r_state <= VCMP;
        // Read data arrives the cycle after ren_ext, i.e. while in VCMP.
        VCMP: begin
          r_rdSum <= r_rdSum ^ bus.rdata_ext;
          if (w_lastWord) begin
            r_state <= CHECK;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= VRD;
          end
        end
        CHECK:   r_state <= (r_rdSum == r_loadSum) ? RUN : ERROR;
        RUN:     r_state <= RUN;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
